// File: rtl/md_sequencer.sv
// md_sequencer: iterative multiply/divide unit owning the HI/LO pair.
// 32-step shift-add multiply or restoring divide, one step per cycle,
// followed by a single sign-fixup cycle before HI/LO are written.
// Handshake: start is taken only in IDLE (and only without flush); while
// busy=1 further starts and MTHI/MTLO writes are ignored, so the hazard unit
// must stall on busy. done pulses for one cycle when HI/LO take a result.
module md_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             mthi_we,
   input  logic             mtlo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dz
);

   localparam int W2 = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;          // op[1]: divide, op[0]: unsigned
   logic             sa_q, sa_d;          // sign of a (signed ops only)
   logic             sb_q, sb_d;          // sign of b (signed ops only)
   logic [WIDTH-1:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
   logic [W2-1:0]    acc_q, acc_d;        // product, or remainder:quotient
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;

   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   mul_sum;
   logic [W2-1:0]    mul_next;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;
   logic             q_bit;
   logic [WIDTH-1:0] rem_new;
   logic [W2-1:0]    div_next;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Operand magnitudes and one step of each iterative algorithm
   always_comb begin
      a_abs = (!op[0] && a[WIDTH-1]) ? -a : a;
      b_abs = (!op[0] && b[WIDTH-1]) ? -b : b;
      // Shift-add: add multiplicand into the upper half on multiplier LSB,
      // then shift the whole 64-bit register right (carry enters at the top).
      mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      // Restoring divide: the shifted remainder can need WIDTH+1 bits.
      rem_sh   = acc_q[W2-1:WIDTH-1];
      diff     = {1'b0, rem_sh} - {2'b00, opnd_q};
      q_bit    = ~diff[WIDTH+1];
      rem_new  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      div_next = {rem_new, acc_q[WIDTH-2:0], q_bit};
      // Sign fixup; sa_q/sb_q are zero for unsigned ops
      prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = sa_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
   end

   // Next-state and datapath update for the IDLE/CALC/FIX sequence
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (mthi_we) hi_d = wdata;
            if (mtlo_we) lo_d = wdata;
            if (start && !flush) begin
               state_d = S_CALC;
               op_d    = op;
               sa_d    = !op[0] && a[WIDTH-1];
               sb_d    = !op[0] && b[WIDTH-1];
               opnd_d  = op[1] ? b_abs : a_abs;
               acc_d   = {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
               cnt_d   = '0;
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = op_q[1] ? div_next : mul_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (op_q[1]) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
                  dz_d = (opnd_q == '0);
               end else begin
                  hi_d = prod_fix[W2-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
                  dz_d = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs, cleared by asynchronous reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         opnd_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign dz   = dz_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: table of directed ops, hand-written multi-cycle
// corner sequences (flush, ignored start, MTHI/MTLO, reset mid-op) and
// random ops checked against an arithmetic reference model.
module tb_md_sequencer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        flush;
   logic        mthi_we, mtlo_we;
   logic [31:0] wdata;
   logic        busy, done, dz;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;
   logic [64:0] exp_q[$];   // {dz, hi, lo}

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t vecs[7];

   md_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
      .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: results straight from the arithmetic definitions
   function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      int          ix, iy;
      longint      sx, sy, q, r;
      logic [63:0] p;
      logic [31:0] h, l;
      logic        z;
      ix = x; iy = y;
      sx = ix; sy = iy;
      z = 1'b0;
      h = '0; l = '0;
      case (o)
         2'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
         2'd1: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
         2'd2: begin
            if (y == 0) begin
               z = 1'b1; h = x; l = x[31] ? 32'h1 : 32'hFFFFFFFF;
            end else begin
               q = sx / sy; r = sx % sy;
               l = 32'(q); h = 32'(r);
            end
         end
         default: begin
            if (y == 0) begin
               z = 1'b1; h = x; l = 32'hFFFFFFFF;
            end else begin
               l = x / y; h = x % y;
            end
         end
      endcase
      return {z, h, l};
   endfunction

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   // One complete op; latency, busy width and results checked at done
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [64:0] e_in, input string tag);
      int n, busy_cnt;
      logic [64:0] e;
      exp_q.push_back(e_in);
      issue(o, x, y);
      n = 1; busy_cnt = 0;
      while (done !== 1'b1 && n < 100) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         n++;
      end
      e = exp_q.pop_front();
      check({tag, " latency"}, 32'(n), 32'd34);
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
      check({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
      check({tag, " hi"}, hi, e[63:32]);
      check({tag, " lo"}, lo, e[31:0]);
      check({tag, " dz"}, {31'b0, dz}, {31'b0, e[64]});
      @(negedge clk);
      check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      logic [31:0] hi_s, lo_s, x, y;
      logic [1:0]  o;
      int dcnt, k;

      rstn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;

      // reset state
      #12;
      check("rst hi", hi, 32'h0);
      check("rst lo", lo, 32'h0);
      check("rst busy", {31'b0, busy}, 32'h0);
      check("rst done", {31'b0, done}, 32'h0);
      check("rst dz", {31'b0, dz}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;

      // directed table
      vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[2] = '{2'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
      vecs[3] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[5] = '{2'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
      vecs[6] = '{2'd1, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
      for (int i = 0; i < 7; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].dz, vecs[i].hi, vecs[i].lo},
                $sformatf("vec%0d", i));

      // MTLO in IDLE
      @(negedge clk);
      mtlo_we = 1'b1; wdata = 32'h12345678;
      @(negedge clk);
      mtlo_we = 1'b0;
      check("mtlo lo", lo, 32'h12345678);
      check("mtlo hi", hi, 32'h0);

      // start ignored mid-op, then flush at cycle 10
      hi_s = hi; lo_s = lo;
      issue(2'd1, 32'd4, 32'd4);          // now cycle 1
      repeat (4) @(negedge clk);          // cycle 5
      start = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);          // cycle 10
      check("flush busy_before", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy_after", {31'b0, busy}, 32'd0);
      dcnt = done ? 1 : 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dcnt++;
         if (busy) dcnt++;
      end
      check("flush no_done", 32'(dcnt), 32'd0);
      check("flush hi_kept", hi, hi_s);
      check("flush lo_kept", lo, lo_s);

      // flush together with start in IDLE drops the start
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start busy", {31'b0, busy}, 32'd0);

      // MTHI on the accepted start edge survives a flush
      @(negedge clk);
      start = 1'b1; op = 2'd3; a = 32'd50; b = 32'd3; mthi_we = 1'b1; wdata = 32'hCAFEF00D;
      @(negedge clk);
      start = 1'b0; mthi_we = 1'b0;
      check("mthi_start hi", hi, 32'hCAFEF00D);
      check("mthi_start busy", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("mthi_flush busy", {31'b0, busy}, 32'd0);
      check("mthi_flush hi", hi, 32'hCAFEF00D);

      // MTHI while busy is ignored; op then completes normally
      issue(2'd1, 32'd3, 32'd5);          // cycle 1
      repeat (2) @(negedge clk);          // cycle 3
      mthi_we = 1'b1; wdata = 32'hDEADBEEF;
      @(negedge clk);
      mthi_we = 1'b0;
      check("mthi_busy hi", hi, 32'hCAFEF00D);
      k = 4;
      while (done !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("mthi_busy latency", 32'(k), 32'd34);
      check("mthi_busy res_hi", hi, 32'h0);
      check("mthi_busy res_lo", lo, 32'd15);

      // reset mid-CALC after a divide-by-zero left dz set
      run_op(2'd3, 32'd7, 32'd0, {1'b1, 32'd7, 32'hFFFFFFFF}, "dz7");
      issue(2'd0, 32'd123, 32'd456);
      repeat (14) @(negedge clk);
      check("rst_mid busy_before", {31'b0, busy}, 32'd1);
      rstn = 1'b0;
      #1;
      check("rst_mid hi", hi, 32'h0);
      check("rst_mid lo", lo, 32'h0);
      check("rst_mid busy", {31'b0, busy}, 32'h0);
      check("rst_mid dz", {31'b0, dz}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      dcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      check("rst_mid no_done", 32'(dcnt), 32'd0);

      // random ops against the reference model
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         if ($urandom_range(0, 5) == 0) x = 32'h80000000;
         if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 15));
         if ($urandom_range(0, 7) == 0) y = 32'h0;
         if ($urandom_range(0, 9) == 0) y = 32'hFFFFFFFF;
         run_op(o, x, y, model(o, x, y), $sformatf("rnd%0d op%0d %h %h", i, o, x, y));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the pipeline CPU.
- Sits beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs an iterative 32-step shift-add multiply or restoring divide, one step per cycle.
- Raises busy so the hazard unit stalls dependent MFHI/MFLO and further MD ops; services MTHI/MTLO writes and HI/LO reads.

Parameters:
- WIDTH, 32, operand/HI/LO width (only 32 is verified)
- CNT_W, 5, iteration counter width (log2 WIDTH)

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  launch an op; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- flush  in  1  abort the in-flight op (branch/exception squash)
- mthi_we  in  1  write HI from wdata
- mtlo_we  in  1  write LO from wdata
- wdata  in  32  MTHI/MTLO data
- busy  out  1  op in flight (CALC or FIX state)
- done  out  1  one-cycle pulse: HI/LO just updated by a completed op
- hi  out  32  HI register
- lo  out  32  LO register
- dz  out  1  sticky per-op flag: last completed divide had b==0

Behaviour:
- Reset (async, rstn=0): state IDLE; hi=0, lo=0, busy=0, done=0, dz=0; counter and internal accumulators cleared. Reset mid-op discards the op; no done.
- FSM states: IDLE, CALC, FIX.
- IDLE → CALC on a clock edge with start=1 and flush=0:
  - latch op.
  - Signed ops: latch |a| and |b|, plus sign bits.
  - Unsigned ops: latch raw a and b.
  - Clear counter.
- CALC: one iteration per cycle, counter 0..31.
  - Multiply: 64-bit product register, shift-add on the LSB of the multiplier.
  - Divide: 64-bit remainder:quotient register, shift left, trial-subtract divisor, set quotient bit if no borrow.
  - After the counter reaches 31, the next edge goes to FIX.
- FIX: one cycle, then the next edge writes HI/LO, pulses done for one cycle, and returns to IDLE.
  - Signed multiply: negate the 64-bit product if sign(a)^sign(b).
  - Signed divide: negate the quotient if sign(a)^sign(b); negate the remainder if sign(a).
  - MULT*: hi=product[63:32], lo=product[31:0].
  - DIV*: lo=quotient, hi=remainder.
- Latency: start edge T0; busy=1 during cycles after T0 through after T32; HI/LO updated and done=1 in the cycle after edge T33; busy=0 in that same cycle.
- Divide by zero:
  - No trap; completes with normal latency.
  - Magnitude result is quotient=FFFFFFFF, remainder=|a|; signed fixup is then applied as usual.
  - dz=1 on completion; dz is cleared on completion of any later op.
- Overflow: DIV 80000000/FFFFFFFF gives lo=80000000, hi=0. No flag.
- start while busy: ignored (no queue). The hazard unit must stall on busy.
- flush:
  - In CALC/FIX: next edge returns to IDLE; HI/LO unchanged; no done.
  - flush together with start in IDLE: start dropped.
- MTHI/MTLO:
  - In IDLE: write on the next edge.
  - While busy: ignored.
  - Same edge as an accepted start: the write happens, and is later overwritten at completion (or kept if the op is flushed).
- Outputs hi/lo are direct register outputs: no combinational path from inputs.

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF, start at T0 → busy 33 cycles; done after edge T33; hi=FFFFFFFE, lo=00000001.
- MULT a=FFFFFFFD(-3) b=00000007 → hi=FFFFFFFF, lo=FFFFFFEB; then DIVU a=100 b=7 → lo=0000000E, hi=00000002.
- DIV a=FFFFFFF9(-7) b=2 → lo=FFFFFFFD, hi=FFFFFFFF, dz=0; then DIV a=80000000 b=FFFFFFFF → lo=80000000, hi=0.
- DIVU a=5 b=0 → lo=FFFFFFFF, hi=00000005, dz=1; a following MULTU 2*3 clears dz, lo=6.
- Start MULTU 4*4, assert flush at cycle 10 → busy drops next cycle, no done, hi/lo keep prior values; a start pulsed at cycle 5 of a running op is ignored.
- MTLO wdata=12345678 in IDLE → lo=12345678 next cycle; MTHI during busy → hi unchanged; rstn low mid-CALC → hi=lo=0, busy=0 immediately.
